// File: rtl/noc_pkg.sv
// Shared field layout, source IDs and beat type for the operand pairing path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package noc_pkg;

    localparam int TDATAW_DEF = 32;
    localparam int SRCW_DEF   = 4;
    localparam int OPW_DEF    = 16;

    // Source ID occupies the top bits of a flit, the operand sits at the bottom
    localparam int SRC_MSB = TDATAW_DEF - 1;
    localparam int SRC_LSB = TDATAW_DEF - SRCW_DEF;
    localparam int OP_LSB  = 0;

    // Generator at mesh node (0,0) supplies A, generator at (1,0) supplies B
    localparam logic [SRCW_DEF-1:0] NODE_GEN1_ID = 4'h0;
    localparam logic [SRCW_DEF-1:0] NODE_GEN2_ID = 4'h2;

    // One output beat: B in the upper half, A in the lower half
    typedef struct packed {
        logic [OPW_DEF-1:0] b;
        logic [OPW_DEF-1:0] a;
    } operand_pair_t;

endpackage

// File: rtl/op_sync_fifo.sv
// Small synchronous FIFO holding operands of one source until its partner arrives.
// Latency: a push is visible at head_dat/!empty the cycle after the write edge.
// Backpressure: push ignored when full, pop ignored when empty; caller gates both.
module op_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_dat = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push  = push_vld && !full;
    assign do_pop   = pop_rdy && !empty;

    // Next pointers and storage; simultaneous push and pop keep occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_dat;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // Pointer registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: pointers alone define which entries are valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/axis_operand_pair.sv
// Sorts mesh flits by source into A/B FIFOs and emits one {opB, opA} beat per matched pair.
// Latency: flit accepted in cycle N with partner queued appears on M_TVALID in cycle N+2.
// Backpressure: S_TREADY drops when either FIFO is full; M beat held stable until M_TREADY.
module axis_operand_pair
    import noc_pkg::*;
#(
    parameter int              TDATAW      = TDATAW_DEF,
    parameter int              SRCW        = SRCW_DEF,
    parameter int              OPW         = OPW_DEF,
    parameter logic [SRCW-1:0] SRC_A_ID    = NODE_GEN1_ID,
    parameter logic [SRCW-1:0] SRC_B_ID    = NODE_GEN2_ID,
    parameter int              FIFO_DEPTH  = 4,
    parameter int              NUM_PACKETS = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              AXIS_S_TVALID,
    output logic              AXIS_S_TREADY,
    input  logic [TDATAW-1:0] AXIS_S_TDATA,
    input  logic              AXIS_S_TLAST,
    output logic              AXIS_M_TVALID,
    input  logic              AXIS_M_TREADY,
    output logic [2*OPW-1:0]  AXIS_M_TDATA,
    output logic              AXIS_M_TLAST,
    output logic              DONE,
    output logic [7:0]        DROP_CNT_O
);

    localparam int              CNTW     = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1;
    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(NUM_PACKETS - 1);

    logic [SRCW-1:0]  s_src;
    logic [OPW-1:0]   s_op;
    logic             s_hs;
    logic             push_a;
    logic             push_b;
    logic             drop;
    logic             m_hs;
    logic             pair_pop;

    logic [OPW-1:0]   head_a;
    logic [OPW-1:0]   head_b;
    logic             full_a;
    logic             full_b;
    logic             empty_a;
    logic             empty_b;

    logic             m_vld_q, m_vld_d;
    logic [2*OPW-1:0] m_dat_q, m_dat_d;
    logic             m_last_q, m_last_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    // Frame marker on the input side carries no meaning here; the middle
    // TDATA bits between operand and source ID are padding.
    logic             unused_s_bits;
    assign unused_s_bits = AXIS_S_TLAST ^ (^AXIS_S_TDATA);

    assign s_src = AXIS_S_TDATA[TDATAW-1 -: SRCW];
    assign s_op  = AXIS_S_TDATA[OP_LSB +: OPW];

    // Stall the whole mesh port when either side is full, regardless of source
    assign AXIS_S_TREADY = !RST && !full_a && !full_b;

    assign s_hs     = AXIS_S_TVALID && AXIS_S_TREADY;
    assign push_a   = s_hs && (s_src == SRC_A_ID);
    assign push_b   = s_hs && (s_src == SRC_B_ID);
    assign drop     = s_hs && !push_a && !push_b;
    assign m_hs     = m_vld_q && AXIS_M_TREADY;
    // Both heads leave together; the output slot must be free or draining
    assign pair_pop = !empty_a && !empty_b && (!m_vld_q || AXIS_M_TREADY);

    op_sync_fifo #(
        .WIDTH (OPW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo_a (
        .clk      (CLK),
        .rst      (RST),
        .push_vld (push_a),
        .push_dat (s_op),
        .pop_rdy  (pair_pop),
        .head_dat (head_a),
        .full     (full_a),
        .empty    (empty_a)
    );

    op_sync_fifo #(
        .WIDTH (OPW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo_b (
        .clk      (CLK),
        .rst      (RST),
        .push_vld (push_b),
        .push_dat (s_op),
        .pop_rdy  (pair_pop),
        .head_dat (head_b),
        .full     (full_b),
        .empty    (empty_b)
    );

    // Pair counter, output beat register and saturating drop counter
    always_comb begin
        cnt_d      = cnt_q;
        m_vld_d    = m_vld_q;
        m_dat_d    = m_dat_q;
        m_last_d   = m_last_q;
        drop_cnt_d = drop_cnt_q;

        if (m_hs) begin
            cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
        end

        // The newly loaded beat's frame index is the post-handshake count
        if (pair_pop) begin
            m_vld_d  = 1'b1;
            m_dat_d  = {head_b, head_a};
            m_last_d = (cnt_d == LAST_IDX);
        end else if (m_hs) begin
            m_vld_d  = 1'b0;
            m_last_d = 1'b0;
        end

        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // State registers with synchronous reset; reset discards any held beat
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q      <= '0;
            m_vld_q    <= 1'b0;
            m_dat_q    <= '0;
            m_last_q   <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            cnt_q      <= cnt_d;
            m_vld_q    <= m_vld_d;
            m_dat_q    <= m_dat_d;
            m_last_q   <= m_last_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign AXIS_M_TVALID = m_vld_q;
    assign AXIS_M_TDATA  = m_dat_q;
    assign AXIS_M_TLAST  = m_last_q;
    assign DONE          = m_hs && m_last_q;
    assign DROP_CNT_O    = drop_cnt_q;

endmodule

// File: tb/tb_axis_operand_pair.sv
module tb_axis_operand_pair;
    import noc_pkg::*;

    localparam int              TDATAW = 32;
    localparam int              SRCW   = 4;
    localparam int              OPW    = 16;
    localparam int              DEPTH  = 4;
    localparam int              NPK    = 16;
    localparam logic [SRCW-1:0] SA     = NODE_GEN1_ID;
    localparam logic [SRCW-1:0] SB     = NODE_GEN2_ID;

    logic              CLK = 1'b0;
    logic              RST;
    logic              AXIS_S_TVALID;
    logic              AXIS_S_TREADY;
    logic [TDATAW-1:0] AXIS_S_TDATA;
    logic              AXIS_S_TLAST;
    logic              AXIS_M_TVALID;
    logic              AXIS_M_TREADY;
    logic [2*OPW-1:0]  AXIS_M_TDATA;
    logic              AXIS_M_TLAST;
    logic              DONE;
    logic [7:0]        DROP_CNT_O;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    axis_operand_pair #(
        .TDATAW      (TDATAW),
        .SRCW        (SRCW),
        .OPW         (OPW),
        .SRC_A_ID    (SA),
        .SRC_B_ID    (SB),
        .FIFO_DEPTH  (DEPTH),
        .NUM_PACKETS (NPK)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .AXIS_S_TVALID (AXIS_S_TVALID),
        .AXIS_S_TREADY (AXIS_S_TREADY),
        .AXIS_S_TDATA  (AXIS_S_TDATA),
        .AXIS_S_TLAST  (AXIS_S_TLAST),
        .AXIS_M_TVALID (AXIS_M_TVALID),
        .AXIS_M_TREADY (AXIS_M_TREADY),
        .AXIS_M_TDATA  (AXIS_M_TDATA),
        .AXIS_M_TLAST  (AXIS_M_TLAST),
        .DONE          (DONE),
        .DROP_CNT_O    (DROP_CNT_O)
    );

    function automatic logic [TDATAW-1:0] mk_flit(input logic [SRCW-1:0] src, input logic [OPW-1:0] op);
        logic [TDATAW-1:0] f;
        f = '0;
        f[SRC_MSB:SRC_LSB] = src;
        f[OP_LSB +: OPW]   = op;
        return f;
    endfunction

    function automatic logic [2*OPW-1:0] mk_pair(input logic [OPW-1:0] b, input logic [OPW-1:0] a);
        operand_pair_t p;
        p.b = b;
        p.a = a;
        return p;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST           = 1'b1;
        AXIS_S_TVALID = 1'b0;
        AXIS_S_TDATA  = '0;
        AXIS_S_TLAST  = 1'b0;
        AXIS_M_TREADY = 1'b0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    // Present one flit and return #1 after the edge on which it was accepted
    task automatic send_flit(input logic [SRCW-1:0] src, input logic [OPW-1:0] op);
        AXIS_S_TVALID = 1'b1;
        AXIS_S_TDATA  = mk_flit(src, op);
        AXIS_S_TLAST  = 1'($urandom_range(0, 1));
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (AXIS_S_TREADY) begin
                @(posedge CLK);
                #1;
                AXIS_S_TVALID = 1'b0;
                return;
            end
        end
        n_vec++;
        n_err++;
        $display("FAIL send_timeout: flit src=%h op=%h never accepted, required accept within 50 cycles", src, op);
        AXIS_S_TVALID = 1'b0;
    endtask

    task automatic test_reset();
        RST           = 1'b1;
        AXIS_S_TVALID = 1'b1;
        AXIS_S_TDATA  = mk_flit(SA, 16'h1234);
        AXIS_S_TLAST  = 1'b0;
        AXIS_M_TREADY = 1'b1;
        tick();
        tick();
        n_vec++; if (AXIS_S_TREADY !== 1'b0) begin n_err++; $display("FAIL reset_tready: got %b need 0", AXIS_S_TREADY); end
        n_vec++; if (AXIS_M_TVALID !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b need 0", AXIS_M_TVALID); end
        n_vec++; if (AXIS_M_TLAST !== 1'b0) begin n_err++; $display("FAIL reset_tlast: got %b need 0", AXIS_M_TLAST); end
        n_vec++; if (DONE !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b need 0", DONE); end
        n_vec++; if (AXIS_M_TDATA !== '0) begin n_err++; $display("FAIL reset_tdata: got %h need 0", AXIS_M_TDATA); end
        n_vec++; if (DROP_CNT_O !== 8'd0) begin n_err++; $display("FAIL reset_drop: got %0d need 0", DROP_CNT_O); end
        RST           = 1'b0;
        AXIS_S_TVALID = 1'b0;
        #1;
        n_vec++; if (AXIS_S_TREADY !== 1'b1) begin n_err++; $display("FAIL post_reset_tready: got %b need 1", AXIS_S_TREADY); end
    endtask

    task automatic test_basic_latency();
        do_reset();
        AXIS_M_TREADY = 1'b1;
        send_flit(SA, 16'h0003);
        send_flit(SB, 16'h0005);
        n_vec++; if (AXIS_M_TVALID !== 1'b0) begin n_err++; $display("FAIL lat_n1_tvalid: got %b need 0", AXIS_M_TVALID); end
        tick();
        n_vec++; if (AXIS_M_TVALID !== 1'b1) begin n_err++; $display("FAIL lat_n2_tvalid: got %b need 1", AXIS_M_TVALID); end
        n_vec++; if (AXIS_M_TDATA !== 32'h0005_0003) begin n_err++; $display("FAIL lat_tdata: got %h need 00050003", AXIS_M_TDATA); end
        n_vec++; if (AXIS_M_TLAST !== 1'b0) begin n_err++; $display("FAIL lat_tlast: got %b need 0", AXIS_M_TLAST); end
        tick();
        n_vec++; if (AXIS_M_TVALID !== 1'b0) begin n_err++; $display("FAIL lat_drained: got %b need 0", AXIS_M_TVALID); end
    endtask

    task automatic test_fifo_full();
        logic [2*OPW-1:0] exp_beats [4];
        do_reset();
        for (int i = 1; i <= 4; i++) send_flit(SA, 16'(i));
        n_vec++; if (AXIS_S_TREADY !== 1'b0) begin n_err++; $display("FAIL full_tready: got %b need 0", AXIS_S_TREADY); end
        AXIS_S_TVALID = 1'b1;
        AXIS_S_TDATA  = mk_flit(SB, 16'h0010);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            n_vec++; if (AXIS_S_TREADY !== 1'b0) begin n_err++; $display("FAIL full_stall_tready[%0d]: got %b need 0", i, AXIS_S_TREADY); end
            n_vec++; if (AXIS_M_TVALID !== 1'b0) begin n_err++; $display("FAIL full_stall_tvalid[%0d]: got %b need 0", i, AXIS_M_TVALID); end
        end
        AXIS_S_TVALID = 1'b0;
        // Ordering through the FIFOs with the output held back
        do_reset();
        send_flit(SA, 16'h0001);
        send_flit(SA, 16'h0002);
        send_flit(SA, 16'h0003);
        send_flit(SB, 16'h0010);
        send_flit(SA, 16'h0004);
        send_flit(SB, 16'h0020);
        send_flit(SB, 16'h0030);
        send_flit(SB, 16'h0040);
        tick();
        exp_beats[0] = mk_pair(16'h0010, 16'h0001);
        exp_beats[1] = mk_pair(16'h0020, 16'h0002);
        exp_beats[2] = mk_pair(16'h0030, 16'h0003);
        exp_beats[3] = mk_pair(16'h0040, 16'h0004);
        AXIS_M_TREADY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_vec++; if (AXIS_M_TVALID !== 1'b1) begin n_err++; $display("FAIL order_tvalid[%0d]: got %b need 1", k, AXIS_M_TVALID); end
            n_vec++; if (AXIS_M_TDATA !== exp_beats[k]) begin n_err++; $display("FAIL order_tdata[%0d]: got %h need %h", k, AXIS_M_TDATA, exp_beats[k]); end
            n_vec++; if (AXIS_M_TLAST !== 1'b0) begin n_err++; $display("FAIL order_tlast[%0d]: got %b need 0", k, AXIS_M_TLAST); end
            tick();
        end
        n_vec++; if (AXIS_M_TVALID !== 1'b0) begin n_err++; $display("FAIL order_empty: got %b need 0", AXIS_M_TVALID); end
    endtask

    task automatic test_drop();
        do_reset();
        send_flit(4'h7, 16'h0055);
        n_vec++; if (DROP_CNT_O !== 8'd1) begin n_err++; $display("FAIL drop_cnt: got %0d need 1", DROP_CNT_O); end
        send_flit(SA, 16'h0011);
        send_flit(SB, 16'h0022);
        tick();
        n_vec++; if (AXIS_M_TVALID !== 1'b1) begin n_err++; $display("FAIL drop_pair_tvalid: got %b need 1", AXIS_M_TVALID); end
        n_vec++; if (AXIS_M_TDATA !== 32'h0022_0011) begin n_err++; $display("FAIL drop_pair_tdata: got %h need 00220011", AXIS_M_TDATA); end
        n_vec++; if (DROP_CNT_O !== 8'd1) begin n_err++; $display("FAIL drop_cnt_after: got %0d need 1", DROP_CNT_O); end
        // Saturation at 255
        for (int i = 0; i < 262; i++) send_flit(4'(5 + (i % 9)) == SB ? 4'h1 : 4'(5 + (i % 9)), 16'(i));
        n_vec++; if (DROP_CNT_O !== 8'd255) begin n_err++; $display("FAIL drop_saturate: got %0d need 255", DROP_CNT_O); end
        n_vec++; if (AXIS_M_TDATA !== 32'h0022_0011) begin n_err++; $display("FAIL drop_no_push: got %h need 00220011", AXIS_M_TDATA); end
    endtask

    task automatic test_backpressure();
        logic [2*OPW-1:0] held;
        do_reset();
        send_flit(SA, 16'hAAAA);
        send_flit(SB, 16'hBBBB);
        send_flit(SA, 16'h1234);
        send_flit(SB, 16'h5678);
        tick();
        held = mk_pair(16'hBBBB, 16'hAAAA);
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (AXIS_M_TVALID !== 1'b1) begin n_err++; $display("FAIL bp_tvalid[%0d]: got %b need 1", i, AXIS_M_TVALID); end
            n_vec++; if (AXIS_M_TDATA !== held) begin n_err++; $display("FAIL bp_tdata[%0d]: got %h need %h", i, AXIS_M_TDATA, held); end
            tick();
        end
        AXIS_M_TREADY = 1'b1;
        #1;
        n_vec++; if (AXIS_M_TDATA !== held) begin n_err++; $display("FAIL bp_release0: got %h need %h", AXIS_M_TDATA, held); end
        tick();
        n_vec++; if (AXIS_M_TVALID !== 1'b1 || AXIS_M_TDATA !== mk_pair(16'h5678, 16'h1234)) begin
            n_err++; $display("FAIL bp_release1: got vld=%b dat=%h need vld=1 dat=56781234", AXIS_M_TVALID, AXIS_M_TDATA);
        end
        tick();
        n_vec++; if (AXIS_M_TVALID !== 1'b0) begin n_err++; $display("FAIL bp_no_dup: got %b need 0", AXIS_M_TVALID); end
    endtask

    task automatic test_frame();
        logic [OPW-1:0] a;
        logic [OPW-1:0] b;
        logic           last_exp;
        do_reset();
        AXIS_M_TREADY = 1'b1;
        for (int i = 0; i < NPK + 1; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            send_flit(SA, a);
            n_vec++; if (DONE !== 1'b0 || AXIS_M_TVALID !== 1'b0) begin
                n_err++; $display("FAIL frame_idle[%0d]: got done=%b vld=%b need 0 0", i, DONE, AXIS_M_TVALID);
            end
            send_flit(SB, b);
            tick();
            last_exp = (i == NPK - 1);
            n_vec++; if (AXIS_M_TVALID !== 1'b1 || AXIS_M_TDATA !== mk_pair(b, a)) begin
                n_err++; $display("FAIL frame_beat[%0d]: got vld=%b dat=%h need vld=1 dat=%h", i, AXIS_M_TVALID, AXIS_M_TDATA, mk_pair(b, a));
            end
            n_vec++; if (AXIS_M_TLAST !== last_exp) begin n_err++; $display("FAIL frame_tlast[%0d]: got %b need %b", i, AXIS_M_TLAST, last_exp); end
            n_vec++; if (DONE !== last_exp) begin n_err++; $display("FAIL frame_done[%0d]: got %b need %b", i, DONE, last_exp); end
        end
        tick();
        n_vec++; if (DONE !== 1'b0) begin n_err++; $display("FAIL frame_done_end: got %b need 0", DONE); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        send_flit(SA, 16'h0001);
        send_flit(SA, 16'h0002);
        send_flit(SA, 16'h0003);
        send_flit(SB, 16'h0004);
        tick();
        n_vec++; if (AXIS_M_TVALID !== 1'b1) begin n_err++; $display("FAIL mid_held: got %b need 1", AXIS_M_TVALID); end
        RST = 1'b1;
        tick();
        n_vec++; if (AXIS_M_TVALID !== 1'b0) begin n_err++; $display("FAIL mid_tvalid: got %b need 0", AXIS_M_TVALID); end
        n_vec++; if (AXIS_M_TDATA !== '0) begin n_err++; $display("FAIL mid_tdata: got %h need 0", AXIS_M_TDATA); end
        n_vec++; if (AXIS_S_TREADY !== 1'b0) begin n_err++; $display("FAIL mid_tready: got %b need 0", AXIS_S_TREADY); end
        RST = 1'b0;
        AXIS_M_TREADY = 1'b1;
        send_flit(SB, 16'h0009);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if (AXIS_M_TVALID !== 1'b0) begin n_err++; $display("FAIL mid_orphan[%0d]: got %b need 0", i, AXIS_M_TVALID); end
        end
    endtask

    task automatic test_random();
        logic [OPW-1:0]   qa [$];
        logic [OPW-1:0]   qb [$];
        operand_pair_t    exp;
        logic [SRCW-1:0]  src;
        logic             acc;
        logic             last_exp;
        int               beats;
        int               drops;
        int               d;
        int               r;
        int               pending;
        beats = 0;
        drops = 0;
        do_reset();
        for (int cyc = 0; cyc < 830; cyc++) begin
            if (cyc < 800) begin
                if (!AXIS_S_TVALID && $urandom_range(0, 9) < 7) begin
                    d = qa.size() - qb.size();
                    r = $urandom_range(0, 9);
                    if (r < 1) begin
                        src = 4'($urandom_range(0, 13) + 1);
                        if (src >= 4'h2) src = src + 4'h1;
                    end else if (d >= 3) src = SB;
                    else if (d <= -3) src = SA;
                    else src = (r < 5) ? SA : SB;
                    AXIS_S_TVALID = 1'b1;
                    AXIS_S_TDATA  = mk_flit(src, 16'($urandom));
                end
                AXIS_M_TREADY = ($urandom_range(0, 9) < 6);
            end else begin
                AXIS_S_TVALID = 1'b0;
                AXIS_M_TREADY = 1'b1;
            end
            @(negedge CLK);
            acc = AXIS_S_TVALID && AXIS_S_TREADY;
            if (acc) begin
                src = AXIS_S_TDATA[SRC_MSB:SRC_LSB];
                if (src == SA) qa.push_back(AXIS_S_TDATA[OP_LSB +: OPW]);
                else if (src == SB) qb.push_back(AXIS_S_TDATA[OP_LSB +: OPW]);
                else drops++;
            end
            if (AXIS_M_TVALID && AXIS_M_TREADY) begin
                last_exp = ((beats % NPK) == NPK - 1);
                n_vec++;
                if (qa.size() == 0 || qb.size() == 0) begin
                    n_err++; $display("FAIL rnd_extra_beat[%0d]: got dat=%h with no matched pair pending", beats, AXIS_M_TDATA);
                end else begin
                    exp.a = qa.pop_front();
                    exp.b = qb.pop_front();
                    if (AXIS_M_TDATA !== exp || AXIS_M_TLAST !== last_exp || DONE !== last_exp) begin
                        n_err++; $display("FAIL rnd_beat[%0d]: got dat=%h last=%b done=%b need dat=%h last=%b done=%b",
                                          beats, AXIS_M_TDATA, AXIS_M_TLAST, DONE, exp, last_exp, last_exp);
                    end
                end
                beats++;
            end else begin
                n_vec++; if (DONE !== 1'b0) begin n_err++; $display("FAIL rnd_done_idle[%0d]: got %b need 0", cyc, DONE); end
            end
            @(posedge CLK);
            #1;
            if (acc) AXIS_S_TVALID = 1'b0;
        end
        pending = (qa.size() < qb.size()) ? qa.size() : qb.size();
        n_vec++; if (pending !== 0) begin n_err++; $display("FAIL rnd_lost_pairs: got %0d pairs never emitted need 0", pending); end
        n_vec++; if (AXIS_M_TVALID !== 1'b0) begin n_err++; $display("FAIL rnd_final_tvalid: got %b need 0", AXIS_M_TVALID); end
        n_vec++; if (DROP_CNT_O !== 8'((drops > 255) ? 255 : drops)) begin
            n_err++; $display("FAIL rnd_drop_cnt: got %0d need %0d", DROP_CNT_O, drops);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_latency();
        test_fifo_full();
        test_drop();
        test_backpressure();
        test_frame();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
